// File: rtl/vc_pipe_domain_arbiter_if.sv
// Handshake bundle between the domain arbiter, its two requesters and the first pipeline stage.
// master = arbiter side, slave = requesters/pipeline side.
interface vc_pipe_domain_arbiter_if;
  logic req0_val;
  logic req0_rdy;
  logic req1_val;
  logic req1_rdy;
  logic pipe_val;
  logic pipe_stall;
  logic pipe_squash;
  logic pipe_empty;
  logic domain;
  logic domain_switch;

  modport master (
    input  req0_val, req1_val, pipe_stall, pipe_squash, pipe_empty,
    output req0_rdy, req1_rdy, pipe_val, domain, domain_switch
  );

  modport slave (
    output req0_val, req1_val, pipe_stall, pipe_squash, pipe_empty,
    input  req0_rdy, req1_rdy, pipe_val, domain, domain_switch
  );
endinterface

// File: rtl/vc_pipe_domain_arbiter.sv
// Two-domain (normal/secure) issue arbiter that drains the shared pipeline on every domain switch.
// Optional VC_PIPE_ARB_CONST_DRAIN_EN: fixed-length drain of NSTAGES cycles.
module vc_pipe_domain_arbiter #(
  parameter int unsigned QUANTUM = 8
`ifdef VC_PIPE_ARB_CONST_DRAIN_EN
  , parameter int unsigned NSTAGES = 3
`endif
) (
  input  logic                            clk,
  input  logic                            reset,
  vc_pipe_domain_arbiter_if.master        arb
);

  localparam int unsigned QW = $clog2(QUANTUM + 1);

  typedef enum logic [1:0] {StRun, StDrain, StSwitch} state_e;

  state_e        state_q, state_d;
  logic          domain_q, domain_d;
  logic [QW-1:0] qcnt_q, qcnt_d;

  logic cur_val, oth_val, go_drain, fire, drain_done;
  logic pipe_val, rdy0, rdy1, dsw;

`ifdef VC_PIPE_ARB_CONST_DRAIN_EN
  localparam int unsigned DW = $clog2(NSTAGES + 1);
  logic [DW-1:0] dcnt_q, dcnt_d;
  // Drain length is fixed so switch time reveals nothing about the prior domain's work.
  assign drain_done = (dcnt_q == '0) && arb.pipe_empty;
`else
  assign drain_done = arb.pipe_empty;
`endif

  assign cur_val  = domain_q ? arb.req1_val : arb.req0_val;
  assign oth_val  = domain_q ? arb.req0_val : arb.req1_val;
  assign go_drain = oth_val && (!cur_val || (qcnt_q == QW'(QUANTUM)));
  assign fire     = (state_q == StRun) && !go_drain && cur_val &&
                    !arb.pipe_stall && !arb.pipe_squash;

  always_comb begin
    state_d  = state_q;
    domain_d = domain_q;
    qcnt_d   = qcnt_q;
    pipe_val = 1'b0;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    dsw      = 1'b0;
`ifdef VC_PIPE_ARB_CONST_DRAIN_EN
    dcnt_d   = dcnt_q;
`endif
    unique case (state_q)
      StRun: begin
        if (go_drain) begin
          state_d = StDrain;
`ifdef VC_PIPE_ARB_CONST_DRAIN_EN
          dcnt_d  = DW'(NSTAGES - 1);
`endif
        end else begin
          pipe_val = cur_val && !arb.pipe_squash;
          if (fire) begin
            rdy0 = !domain_q;
            rdy1 = domain_q;
            if (qcnt_q != QW'(QUANTUM)) qcnt_d = qcnt_q + QW'(1);
          end
        end
      end
      StDrain: begin
        if (drain_done) state_d = StSwitch;
`ifdef VC_PIPE_ARB_CONST_DRAIN_EN
        if (dcnt_q != '0) dcnt_d = dcnt_q - DW'(1);
`endif
      end
      StSwitch: begin
        dsw      = 1'b1;
        domain_d = !domain_q;
        qcnt_d   = '0;
        state_d  = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      domain_q <= 1'b0;
      qcnt_q   <= '0;
`ifdef VC_PIPE_ARB_CONST_DRAIN_EN
      dcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      domain_q <= domain_d;
      qcnt_q   <= qcnt_d;
`ifdef VC_PIPE_ARB_CONST_DRAIN_EN
      dcnt_q   <= dcnt_d;
`endif
    end
  end

  // Outputs are forced low while reset is held so nothing issues during reset.
  assign arb.pipe_val      = pipe_val && !reset;
  assign arb.req0_rdy      = rdy0 && !reset;
  assign arb.req1_rdy      = rdy1 && !reset;
  assign arb.domain        = domain_q && !reset;
  assign arb.domain_switch = dsw && !reset;

  a_rdy0_ok: assert property (@(posedge clk) disable iff (reset)
    arb.req0_rdy |-> (!arb.domain && arb.pipe_val && !arb.pipe_stall && !arb.pipe_squash));
  a_rdy1_ok: assert property (@(posedge clk) disable iff (reset)
    arb.req1_rdy |-> (arb.domain && arb.pipe_val && !arb.pipe_stall && !arb.pipe_squash));

`ifdef VC_PIPE_ARB_CONST_DRAIN_EN
  // Pipeline still busy after the fixed drain window: the constant-time guarantee is broken.
  a_const_drain: assert property (@(posedge clk) disable iff (reset)
    (state_q == StDrain && dcnt_q == '0) |-> arb.pipe_empty);
`endif

endmodule

// File: tb/tb_vc_pipe_domain_arbiter.sv
// Randomised scoreboard bench for vc_pipe_domain_arbiter against a behavioural model.
module tb_vc_pipe_domain_arbiter;

  localparam int unsigned QUANTUM = 8;
  localparam int unsigned NSTAGES = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_pipe_domain_arbiter_if intf ();

`ifdef VC_PIPE_ARB_CONST_DRAIN_EN
  vc_pipe_domain_arbiter #(.QUANTUM(QUANTUM), .NSTAGES(NSTAGES)) dut (
    .clk(clk), .reset(reset), .arb(intf.master));
`else
  vc_pipe_domain_arbiter #(.QUANTUM(QUANTUM)) dut (
    .clk(clk), .reset(reset), .arb(intf.master));
`endif

  typedef struct packed {
    logic r0, r1, pv, dom, ds;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  // Reference model: which domain owns the pipe, issues granted since it took over,
  // and how the hand-over is progressing.
  int m_dom         = 0;
  int m_issued      = 0;
  bit m_handing     = 0;   // waiting for the pipe to empty
  bit m_flip_now    = 0;   // hand-over completes this cycle
  int m_drain_cycle = 0;

  task automatic check(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %b, required %b", name, cyc, act, req);
    end
  endtask

  task automatic step(input bit rst, input bit r0, input bit r1, input bit st,
                      input bit sq, input bit emp);
    exp_t e;
    int   mine, other;
    @(posedge clk);
    #1;
    cyc++;
    reset            = rst;
    intf.req0_val    = r0;
    intf.req1_val    = r1;
    intf.pipe_stall  = st;
    intf.pipe_squash = sq;
    intf.pipe_empty  = emp;
    e = '0;
    mine  = (m_dom == 1) ? int'(r1) : int'(r0);
    other = (m_dom == 1) ? int'(r0) : int'(r1);
    if (rst) begin
      m_dom = 0; m_issued = 0; m_handing = 0; m_flip_now = 0; m_drain_cycle = 0;
    end else begin
      e.dom = (m_dom == 1);
      if (m_flip_now) begin
        e.ds = 1'b1;
        m_dom = 1 - m_dom;
        m_issued = 0;
        m_flip_now = 0;
      end else if (m_handing) begin
        m_drain_cycle++;
`ifdef VC_PIPE_ARB_CONST_DRAIN_EN
        if (m_drain_cycle >= NSTAGES && emp) begin
`else
        if (emp) begin
`endif
          m_handing = 0;
          m_flip_now = 1;
        end
      end else if (other == 1 && (mine == 0 || m_issued == QUANTUM)) begin
        m_handing = 1;
        m_drain_cycle = 0;
      end else begin
        e.pv = (mine == 1) && !sq;
        if (mine == 1 && !st && !sq) begin
          if (m_dom == 0) e.r0 = 1'b1;
          else e.r1 = 1'b1;
          if (m_issued < QUANTUM) m_issued++;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  function automatic bit pct(input int unsigned p);
    return $urandom_range(99) < p;
  endfunction

  // Monitor: compare whatever the driver queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("req0_rdy", intf.req0_rdy, e.r0);
        check("req1_rdy", intf.req1_rdy, e.r1);
        check("pipe_val", intf.pipe_val, e.pv);
        check("domain", intf.domain, e.dom);
        check("domain_switch", intf.domain_switch, e.ds);
      end
    end
  end

  initial begin
    int unsigned p0, p1, pst, psq, pemp;
    reset = 1'b1;
    intf.req0_val = 0; intf.req1_val = 0; intf.pipe_stall = 0;
    intf.pipe_squash = 0; intf.pipe_empty = 0;

    repeat (2) step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);                              // idle after reset: all zero
    repeat (12) step(0, 1, 0, 0, 0, 1);                  // req0 alone, quantum saturates
    repeat (4) step(0, 1, 1, 0, 0, 0);                   // req1 arrives, drain with busy pipe
    repeat (6) step(0, 1, 1, 0, 0, 1);                   // pipe empties, switch to domain 1
    repeat (3) step(0, 0, 1, 1, 0, 1);                   // stalled: pipe_val high, no rdy
    repeat (2) step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 1, 1);                              // squash: nothing issues
    repeat (2) step(0, 0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);                              // hand back to domain 0
    repeat (2) step(0, 1, 0, 0, 0, 0);                   // drain held by busy pipe
    step(1, 1, 0, 0, 0, 0);                              // reset mid-drain
    repeat (3) step(0, 0, 0, 0, 0, 1);
    repeat (4) step(0, 0, 1, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1);                   // both idle: domain held

    for (int seg = 0; seg < 8; seg++) begin
      p0   = 30 + 10 * seg % 70;
      p1   = 90 - 10 * seg;
      pst  = (seg % 3) * 15;
      psq  = (seg % 2) * 10;
      pemp = 20 + 10 * seg;
      for (int i = 0; i < 200; i++)
        step(pct(1), pct(p0), pct(p1), pct(pst), pct(psq), pct(pemp));
    end

    repeat (3) @(posedge clk);
    #5;
    check("scoreboard_empty", exp_q.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
